csa_resolve_unit: RTL and testbench

CSA_RESOLVE_UNIT -- requirements
Module: csa_resolve_unit

---
 rtl/csa_resolve_unit.sv | 137 +++++++++++++
 tb/tb_csa_resolve_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_unit.sv
// ============================================================================
// csa_resolve_unit : resolves a carry-save pair into a binary result, CHUNK bits per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module csa_resolve_unit #(
  parameter int W     = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N     = W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       op_sum_q, op_sum_d;
  logic [W-1:0]       op_carry_q, op_carry_d;
  logic [W-1:0]       result_q, result_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cy_q, cy_d;
  logic               cout_q, cout_d;
  logic [CHUNK:0]     chunk_sum;
  logic               accept;

  assign in_ready   = rstn && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept     = in_valid && in_ready && !flush;
  assign out_valid  = (state_q == HOLD);
  assign out_result = result_q;
  assign out_cout   = cout_q;
  assign out_tag    = tag_q;

  always_comb begin
    state_d    = state_q;
    op_sum_d   = op_sum_q;
    op_carry_d = op_carry_q;
    result_d   = result_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    cy_d       = cy_q;
    cout_d     = cout_q;
    chunk_sum  = {1'b0, op_sum_q[idx_q*CHUNK +: CHUNK]}
               + {1'b0, op_carry_q[idx_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cy_q};

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = ADD;
          op_sum_d   = in_sum;
          op_carry_d = in_carry;
          tag_d      = in_tag;
          idx_d      = '0;
          cy_d       = 1'b0;
        end
      end
      ADD: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        cy_d  = chunk_sum[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = HOLD;
          cout_d  = chunk_sum[CHUNK];
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            state_d    = ADD;
            op_sum_d   = in_sum;
            op_carry_d = in_carry;
            tag_d      = in_tag;
            idx_d      = '0;
            cy_d       = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over both completion and a same-cycle accept.
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      cy_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_sum_q   <= '0;
      op_carry_q <= '0;
      result_q   <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      cy_q       <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_sum_q   <= op_sum_d;
      op_carry_q <= op_carry_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      cy_q       <= cy_d;
      cout_q     <= cout_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csa_resolve_unit.sv
// ============================================================================
// tb_csa_resolve_unit : directed self-checking bench for csa_resolve_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csa_resolve_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sum;
  logic [63:0] in_carry;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_cout;
  logic [3:0]  out_tag;

  int total = 0;
  int bad   = 0;

  csa_resolve_unit #(.W(64), .CHUNK(16), .TAG_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation and advances through its accept edge.
  task automatic do_accept(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t);
    int n;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_tag   = t;
    n = 0;
    #0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic [63:0] r,
                              input logic co, input logic [3:0] t);
    chk({tag, "_lat"},  64'(lat), 64'd4);
    chk({tag, "_res"},  out_result, r);
    chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, co});
    chk({tag, "_tag"},  {60'd0, out_tag}, {60'd0, t});
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [63:0] rs, rc;
    logic [64:0] ref_sum;
    logic [3:0]  rt;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0; in_tag = '0;
    step(); step();
    chk("rst_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_cout",   {63'd0, out_cout}, 64'd0);
    chk("rst_tag",    {60'd0, out_tag}, 64'd0);
    chk("rst_ready",  {63'd0, in_ready}, 64'd0);
    rstn = 1'b1;
    #1;
    chk("rel_ready", {63'd0, in_ready}, 64'd1);

    // Basic: carry crosses the 32-bit boundary
    do_accept(64'h0000_0000_FFFF_FFFF, 64'h1, 4'd5);
    chk("add_ready", {63'd0, in_ready}, 64'd0);
    chk("add_valid", {63'd0, out_valid}, 64'd0);
    wait_valid(lat);
    check_result("basic", lat, 64'h0000_0001_0000_0000, 1'b0, 4'd5);
    step();
    chk("basic_idle", {63'd0, out_valid}, 64'd0);

    // Full ripple through all chunks
    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd1);
    wait_valid(lat);
    check_result("ripple", lat, 64'h0, 1'b1, 4'd1);
    step();

    do_accept(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'd2);
    wait_valid(lat);
    check_result("mixed", lat, 64'h2222_2222_2222_2211, 1'b0, 4'd2);
    step();

    do_accept(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd14);
    wait_valid(lat);
    check_result("msb", lat, 64'h0, 1'b1, 4'd14);
    step();

    // Backpressure, then back-to-back accept on the consuming edge
    out_ready = 1'b0;
    do_accept(64'h10, 64'h20, 4'd3);
    wait_valid(lat);
    check_result("bp", lat, 64'h30, 1'b0, 4'd3);
    in_valid = 1'b1; in_sum = 64'hFFFF; in_carry = 64'h1; in_tag = 4'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_res",   out_result, 64'h30);
      chk("bp_tag",   {60'd0, out_tag}, 64'd3);
      chk("bp_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_valid", {63'd0, out_valid}, 64'd0);
    wait_valid(lat);
    check_result("b2b", lat, 64'h10000, 1'b0, 4'd7);
    step();

    // Flush in the second ADD cycle while a new operation is offered
    do_accept(64'h1, 64'h1, 4'd9);
    step();
    flush = 1'b1; in_valid = 1'b1; in_sum = 64'h5; in_carry = 64'h5; in_tag = 4'd4;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("fl_never_valid", {63'd0, seen}, 64'd0);

    // Flush beats a pending result in HOLD
    out_ready = 1'b0;
    do_accept(64'h3, 64'h4, 4'd6);
    wait_valid(lat);
    check_result("flh", lat, 64'h7, 1'b0, 4'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flh_valid", {63'd0, out_valid}, 64'd0);

    // Reset during HOLD
    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 4'd10);
    wait_valid(lat);
    check_result("rh", lat, 64'h1, 1'b1, 4'd10);
    rstn = 1'b0;
    step();
    chk("rh_valid", {63'd0, out_valid}, 64'd0);
    chk("rh_res",   out_result, 64'd0);
    chk("rh_cout",  {63'd0, out_cout}, 64'd0);
    chk("rh_tag",   {60'd0, out_tag}, 64'd0);
    chk("rh_ready", {63'd0, in_ready}, 64'd0);
    rstn = 1'b1;
    out_ready = 1'b1;
    step();

    // Random operands with random CDB stalls
    for (int n = 0; n < 40; n++) begin
      rs = {$urandom(), $urandom()};
      rc = {$urandom(), $urandom()};
      rt = 4'($urandom_range(0, 15));
      ref_sum = {1'b0, rs} + {1'b0, rc};
      out_ready = 1'b0;
      do_accept(rs, rc, rt);
      lat = 0;
      while (!out_valid && lat < 20) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        lat++;
      end
      check_result("rnd", lat, ref_sum[63:0], ref_sum[64], rt);
      out_ready = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
      out_ready = 1'b1;
      step();
      chk("rnd_done", {63'd0, out_valid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
